// File: rtl/stream_width_converter.sv
`default_nettype none
// ============================================================================
// Module   : stream_width_converter
// Purpose  : Registered valid/ready sample width converter (extend, wrap or
//            saturate) with a two-entry skid buffer and a clamp event counter.
// Revision : 1.0 - initial release
// ============================================================================
module stream_width_converter #(
    parameter int InputWidth  = 8,
    parameter int OutputWidth = 16,
    parameter int CountWidth  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [InputWidth-1:0]  in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OutputWidth-1:0] out_data,
    output logic                   out_sat,
    input  logic                   sat_clr,
    output logic [CountWidth-1:0]  sat_count
);

    logic [OutputWidth-1:0] conv_data;
    logic                   conv_sat;

    generate
        if (OutputWidth > InputWidth) begin : g_widen
            localparam int ExtWidth = OutputWidth - InputWidth;
            logic unused_mode;
            assign unused_mode = in_mode[1];
            assign conv_data   = {{ExtWidth{in_mode[0] & in_data[InputWidth-1]}}, in_data};
            assign conv_sat    = 1'b0;
        end else if (OutputWidth == InputWidth) begin : g_pass
            logic [1:0] unused_mode;
            assign unused_mode = in_mode;
            assign conv_data   = in_data;
            assign conv_sat    = 1'b0;
        end else begin : g_narrow
            localparam int TopWidth = InputWidth - OutputWidth + 1;
            // Signed value fits when every bit from the output sign position up is identical.
            logic [TopWidth-1:0] top_bits;
            logic                fits_signed;
            logic                fits_unsigned;
            assign top_bits      = in_data[InputWidth-1:OutputWidth-1];
            assign fits_signed   = (top_bits == '0) || (top_bits == '1);
            assign fits_unsigned = (in_data[InputWidth-1:OutputWidth] == '0);

            always_comb begin
                conv_data = in_data[OutputWidth-1:0];
                conv_sat  = 1'b0;
                if (in_mode[1]) begin
                    if (in_mode[0]) begin
                        if (!fits_signed) begin
                            conv_sat  = 1'b1;
                            conv_data = {in_data[InputWidth-1],
                                         {(OutputWidth-1){~in_data[InputWidth-1]}}};
                        end
                    end else if (!fits_unsigned) begin
                        conv_sat  = 1'b1;
                        conv_data = '1;
                    end
                end
            end
        end
    endgenerate

    logic                   out_valid_q, out_valid_d;
    logic [OutputWidth-1:0] out_data_q,  out_data_d;
    logic                   out_sat_q,   out_sat_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [OutputWidth-1:0] skid_data_q,  skid_data_d;
    logic                   skid_sat_q,   skid_sat_d;
    logic                   in_ready_q,   in_ready_d;
    logic [CountWidth-1:0]  sat_count_q,  sat_count_d;

    logic accept;
    logic xfer;

    assign accept = in_valid & in_ready_q;
    assign xfer   = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sat_d    = out_sat_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sat_d   = skid_sat_q;
        // Output register refills from the skid entry first so order is preserved.
        if (!out_valid_q || xfer) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_sat_d    = skid_sat_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = conv_data;
                    skid_sat_d  = conv_sat;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = conv_data;
                    out_sat_d  = conv_sat;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = conv_data;
            skid_sat_d   = conv_sat;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (xfer && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sat_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            sat_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sat_q    <= out_sat_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sat_q   <= skid_sat_d;
            in_ready_q   <= in_ready_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_width_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_width_converter
// Purpose  : Directed self-checking bench for an 8->16 and a 16->8 converter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_width_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [7:0]  a_in_data  = '0;
    logic [1:0]  a_in_mode  = '0;
    logic [15:0] a_out_data;
    logic        a_out_sat, a_sat_clr = 1'b0;
    logic [7:0]  a_sat_count;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [15:0] b_in_data  = '0;
    logic [1:0]  b_in_mode  = '0;
    logic [7:0]  b_out_data;
    logic        b_out_sat, b_sat_clr = 1'b0;
    logic [2:0]  b_sat_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_width_converter #(.InputWidth(8), .OutputWidth(16), .CountWidth(8)) u_wide (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_sat(a_out_sat),
        .sat_clr(a_sat_clr), .sat_count(a_sat_count)
    );

    stream_width_converter #(.InputWidth(16), .OutputWidth(8), .CountWidth(3)) u_narrow (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_sat(b_out_sat),
        .sat_clr(b_sat_clr), .sat_count(b_sat_count)
    );

    // Independent 16->8 reference: returns {sat, data}.
    function automatic logic [8:0] model_n(input logic [15:0] d, input logic [1:0] m);
        int v;
        if (!m[1]) return {1'b0, d[7:0]};
        if (m[0]) begin
            v = int'($signed(d));
            if (v > 127)  return {1'b1, 8'h7F};
            if (v < -128) return {1'b1, 8'h80};
            return {1'b0, d[7:0]};
        end
        if (d > 16'd255) return {1'b1, 8'hFF};
        return {1'b0, d[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_a_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_out_data !== 16'h0000) begin failures++; $display("FAIL reset_a_out_data got=%h exp=0000", a_out_data); end
        checks++; if (a_out_sat !== 1'b0) begin failures++; $display("FAIL reset_a_out_sat got=%b exp=0", a_out_sat); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_a_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (a_sat_count !== 8'h00) begin failures++; $display("FAIL reset_a_sat_count got=%h exp=00", a_sat_count); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%b exp=0", b_out_valid); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); end
        checks++; if (b_sat_count !== 3'd0) begin failures++; $display("FAIL reset_b_sat_count got=%0d exp=0", b_sat_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_widen();
        logic [7:0]  din[4]  = '{8'h80, 8'h80, 8'h7F, 8'h80};
        logic [1:0]  mode[4] = '{2'b01, 2'b00, 2'b01, 2'b11};
        logic [15:0] exp[4]  = '{16'hFF80, 16'h0080, 16'h007F, 16'hFF80};
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = din[i];
            a_in_mode  = mode[i];
            tick();
            a_in_valid = 1'b0;
            checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL widen_valid[%0d] got=%b exp=1", i, a_out_valid); end
            checks++; if (a_out_data !== exp[i]) begin failures++; $display("FAIL widen_data[%0d] got=%h exp=%h", i, a_out_data, exp[i]); end
            checks++; if (a_out_sat !== 1'b0) begin failures++; $display("FAIL widen_sat[%0d] got=%b exp=0", i, a_out_sat); end
            tick();
        end
    endtask

    task automatic test_narrow();
        logic [15:0] din[6]  = '{16'h0123, 16'hFE00, 16'hFFF0, 16'h0123, 16'h0100, 16'h00AB};
        logic [1:0]  mode[6] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10};
        logic [7:0]  exp[6]  = '{8'h7F, 8'h80, 8'hF0, 8'h23, 8'hFF, 8'hAB};
        logic        esat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        b_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = din[i];
            b_in_mode  = mode[i];
            tick();
            b_in_valid = 1'b0;
            checks++; if (b_out_valid !== 1'b1) begin failures++; $display("FAIL narrow_valid[%0d] got=%b exp=1", i, b_out_valid); end
            checks++; if (b_out_data !== exp[i]) begin failures++; $display("FAIL narrow_data[%0d] got=%h exp=%h", i, b_out_data, exp[i]); end
            checks++; if (b_out_sat !== esat[i]) begin failures++; $display("FAIL narrow_sat[%0d] got=%b exp=%b", i, b_out_sat, esat[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        bit took;
        a_out_ready = 1'b0;
        a_in_mode   = 2'b01;
        a_in_data   = 8'h11;
        a_in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            took = a_in_valid && a_in_ready;
            tick();
            if (took) begin
                accepted++;
                if (accepted == 1) a_in_data = 8'h92;
                if (accepted == 2) begin
                    a_in_data = 8'h33;
                    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_after_2nd got=%b exp=0", a_in_ready); end
                end
            end
        end
        a_in_valid = 1'b0;
        checks++; if (accepted !== 2) begin failures++; $display("FAIL bp_accept_count got=%0d exp=2", accepted); end
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h0011) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/0011", a_out_valid, a_out_data); end
        a_out_ready = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'hFF92) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/ff92", a_out_valid, a_out_data); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_restored got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_throughput();
        logic [8:0]  exp_q[$];
        logic [8:0]  e;
        logic [15:0] d;
        int sent = 0, got = 0, gaps = 0;
        bit took;
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            d          = 16'(sent * 1237 + 17) ^ 16'(sent << 9);
            b_in_valid = (sent < 100);
            b_in_data  = d;
            b_in_mode  = 2'(sent);
            if (b_out_valid) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if ({b_out_sat, b_out_data} !== e) begin
                    failures++;
                    $display("FAIL tput_beat[%0d] got=%b/%h exp=%b/%h", got - 1, b_out_sat, b_out_data, e[8], e[7:0]);
                end
            end else if (sent > 0 && got < 100) begin
                gaps++;
            end
            took = b_in_valid && b_in_ready;
            if (took) begin
                exp_q.push_back(model_n(d, 2'(sent)));
                sent++;
            end
            tick();
        end
        b_in_valid = 1'b0;
        checks++; if (got !== 100) begin failures++; $display("FAIL tput_count got=%0d exp=100", got); end
        checks++; if (gaps !== 0) begin failures++; $display("FAIL tput_gaps got=%0d exp=0", gaps); end
    endtask

    task automatic test_counter();
        b_out_ready = 1'b1;
        b_sat_clr   = 1'b1;
        tick();
        b_sat_clr   = 1'b0;
        checks++; if (b_sat_count !== 3'd0) begin failures++; $display("FAIL cnt_clear got=%0d exp=0", b_sat_count); end
        b_in_data  = 16'h0123;
        b_in_mode  = 2'b11;
        b_in_valid = 1'b1;
        repeat (9) tick();
        b_in_valid = 1'b0;
        repeat (2) tick();
        checks++; if (b_sat_count !== 3'd7) begin failures++; $display("FAIL cnt_saturate got=%0d exp=7", b_sat_count); end
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid  = 1'b0;
        checks++; if (b_out_valid !== 1'b1 || b_out_sat !== 1'b1) begin failures++; $display("FAIL cnt_pending got=%b/%b exp=1/1", b_out_valid, b_out_sat); end
        b_out_ready = 1'b1;
        b_sat_clr   = 1'b1;
        tick();
        b_sat_clr   = 1'b0;
        checks++; if (b_sat_count !== 3'd0) begin failures++; $display("FAIL cnt_clear_wins got=%0d exp=0", b_sat_count); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL cnt_transferred got=%b exp=0", b_out_valid); end
    endtask

    task automatic test_reset_mid();
        b_out_ready = 1'b1;
        b_in_data   = 16'h0123;
        b_in_mode   = 2'b11;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid  = 1'b0;
        tick();
        checks++; if (b_sat_count !== 3'd1) begin failures++; $display("FAIL rmid_count_pre got=%0d exp=1", b_sat_count); end
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        tick();
        b_in_data   = 16'hFE00;
        tick();
        b_in_valid  = 1'b0;
        checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL rmid_full got=%b exp=0", b_in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_async_valid got=%b exp=0", b_out_valid); end
        checks++; if (b_out_data !== 8'h00) begin failures++; $display("FAIL rmid_async_data got=%h exp=00", b_out_data); end
        #2;
        rst = 1'b0;
        tick();
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", b_in_ready); end
        checks++; if (b_sat_count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", b_sat_count); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_empty got=%b exp=0", b_out_valid); end
        b_out_ready = 1'b1;
        b_in_data   = 16'hFFF0;
        b_in_mode   = 2'b11;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid  = 1'b0;
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'hF0 || b_out_sat !== 1'b0) begin
            failures++;
            $display("FAIL rmid_next_beat got=%b/%h/%b exp=1/f0/0", b_out_valid, b_out_data, b_out_sat);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_widen();
        test_narrow();
        test_backpressure();
        test_throughput();
        test_counter();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout reached=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
